fp_normalizer_pipe: RTL
=======================

Name: fp_normalizer_pipe

Overview:
Parametrised, two-stage pipelined post-add normalizer for the FP arithmetic datapath. It takes a raw adder mantissa, including the carry-out bit, plus the pre-normalization exponent. It returns a normalized mantissa, the adjusted exponent, the shift amount and status flags. Valid/ready handshakes on both sides let it sit between the adder stage and the rounder with backpressure.

Parameters:
MANT_W, 24, mantissa width including hidden bit (24 = FP32, 11 = FP16)
EXP_W, 8, exponent field width
SHIFT_W, $clog2(MANT_W+1), width of shift-count output (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept input this cycle
in_mant  in  MANT_W+1  raw mantissa; bit MANT_W is adder carry-out
in_exp  in  EXP_W  biased exponent before normalization
in_sticky  in  1  sticky bit from alignment stage
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_mant  out  MANT_W  normalized mantissa (hidden bit at MSB when normal)
out_exp  out  EXP_W  adjusted biased exponent
out_shift  out  SHIFT_W  left-shift amount applied (0 on right-shift path)
out_sticky  out  1  in_sticky OR bit lost on right shift
out_zero  out  1  result mantissa zero
out_denorm  out  1  result clamped to subnormal (exponent 0)
out_ovf  out  1  exponent overflow; result is infinity encoding

Behaviour:
- Reset (synchronous, active-high): s1_valid=0, s2_valid=0, all output data/flag registers 0. Any in-flight beats are discarded with no output. in_ready=1 in the first cycle after reset.
- Stage 1 registers the input. It computes lzc = leading zeros of in_mant[MANT_W-1:0], a carry flag and a zero flag.
- Stage 2 shifts the mantissa, adjusts the exponent and registers the outputs. Latency is 2 cycles from accepted input to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake:
  - s1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s1 advances.
  - A transfer occurs when valid && ready.
  - Outputs stay stable while out_valid && !out_ready.
  - Beat order is preserved. Nothing is dropped or duplicated.
- Carry path (in_mant[MANT_W]=1):
  - mant = in_mant >> 1, exp = in_exp+1, shift=0, sticky |= in_mant[0].
  - If in_exp+1 >= 2^EXP_W-1: out_ovf=1, out_exp=all ones, out_mant=0.
- Zero path (in_mant==0): out_zero=1, out_mant=0, out_exp=0, out_shift=0, out_sticky=in_sticky.
- Normal path (in_exp>=1 and lzc <= in_exp-1): mant = in_mant << lzc, exp = in_exp - lzc, shift = lzc.
- Subnormal path (otherwise):
  - shift = (in_exp==0) ? 0 : in_exp-1.
  - out_exp=0, out_denorm=1.
  - out_denorm is not set if the shifted MSB is 1.
- Exponent arithmetic uses EXP_W+1 bits internally, so it never wraps.
- Flags are mutually exclusive: priority ovf > zero > denorm.

Decomposition:
- Package fp_norm_pkg holds:
  - a parameterised result struct (mant, exp, shift, sticky, flags);
  - a flag enum {NORM, ZERO, DENORM, OVF};
  - the FP32 and FP16 MANT_W/EXP_W constants.
- One sub-module: lzc_count. It is a parametrised priority leading-zero counter (WIDTH, output $clog2(WIDTH+1)) and returns WIDTH on all-zero input.
- The top contains the two pipeline stages and the handshake logic.

Test Plan (MANT_W=24, EXP_W=8, out_ready=1 unless stated):
1. in_mant=0x0800000, exp=100 -> 2 cycles later: mant=0x800000, exp=100, shift=0, no flags. Then in_mant=0x0000400, exp=100 -> mant=0x800000, exp=87, shift=13.
2. Carry: in_mant=0x1000001, exp=100 -> mant=0x800000, exp=101, sticky=1. Same mantissa with exp=254 -> out_ovf=1, exp=0xFF, mant=0.
3. Subnormal: in_mant=0x0000001, exp=5 -> shift=4, mant=0x000010, exp=0, out_denorm=1. in_mant=0x0000001, exp=24 -> normal: mant=0x800000, exp=1, shift=23.
4. Zero: in_mant=0, exp=77, sticky=1 -> out_zero=1, exp=0, mant=0, sticky=1.
5. Backpressure: stream 5 beats back-to-back with out_ready low for 4 cycles. in_ready drops after 2 beats are held. Outputs stay stable while stalled. All 5 beats emerge in order with correct values.
6. Assert reset while 2 beats are in flight -> next cycle out_valid=0 and in_ready=1. Neither beat ever appears. A fresh beat has 2-cycle latency.

Source files
------------

// File: rtl/fp_normalizer_pipe_pkg.sv
// Shared definitions for the post-add normalizer.
//   - FP32 / FP16 mantissa and exponent widths
//   - result classification enum used inside the pipeline
// The per-beat result struct depends on MANT_W/EXP_W. A package cannot take
// parameters, so that struct is declared inside fp_normalizer_pipe and built
// from norm_flag_e.
package fp_norm_pkg;

  localparam int FP32_MANT_W = 24;
  localparam int FP32_EXP_W  = 8;
  localparam int FP16_MANT_W = 11;
  localparam int FP16_EXP_W  = 5;

  // One classification per beat, so the flags can never overlap.
  // When several conditions hold, the priority is ovf > zero > denorm.
  typedef enum logic [1:0] {
    NORM   = 2'd0,
    ZERO   = 2'd1,
    DENORM = 2'd2,
    OVF    = 2'd3
  } norm_flag_e;

endpackage

// File: rtl/fp_normalizer_pipe_if.sv
// Handshake bundle between the adder, the normalizer and the rounder.
//   in_valid/in_ready    : upstream handshake
//   in_mant              : raw mantissa (MSB is the adder carry-out)
//   in_exp, in_sticky    : exponent before normalization, and the alignment sticky bit
//   out_valid/out_ready  : downstream handshake
//   out_mant/out_exp/out_shift/out_sticky : normalized result
//   out_zero/out_denorm/out_ovf           : status flags, mutually exclusive
// The master modport is the environment, which drives the input and consumes the output.
// The slave modport is the normalizer.
interface fp_normalizer_pipe_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);
  localparam int SHIFT_W = $clog2(MANT_W + 1);

  logic               in_valid;
  logic               in_ready;
  logic [MANT_W:0]    in_mant;
  logic [EXP_W-1:0]   in_exp;
  logic               in_sticky;

  logic               out_valid;
  logic               out_ready;
  logic [MANT_W-1:0]  out_mant;
  logic [EXP_W-1:0]   out_exp;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_sticky;
  logic               out_zero;
  logic               out_denorm;
  logic               out_ovf;

  modport master (
    output in_valid, in_mant, in_exp, in_sticky, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_shift,
           out_sticky, out_zero, out_denorm, out_ovf
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sticky, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_shift,
           out_sticky, out_zero, out_denorm, out_ovf
  );

endinterface

// File: rtl/fp_normalizer_pipe_lzc.sv
// Priority leading-zero counter.
//   data  : WIDTH-bit input vector
//   count : number of zeros above the most significant set bit. It is WIDTH
//           when data is all zeros.
module lzc_count #(
  parameter int WIDTH = 24,
  localparam int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [OUT_W-1:0] count
);

  // Scan upward so that the highest set bit is the last one to assign.
  always_comb begin
    count = OUT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = OUT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalizer_pipe.sv
// Two-stage post-add normalizer with valid/ready on both sides.
//   clk, reset : clock, and a synchronous active-high reset
//   bus        : fp_normalizer_pipe_if.slave (input beat, output beat, flags)
// Stage 1 registers the beat together with its leading-zero count and its
// carry and zero indications.
// Stage 2 selects carry / zero / normal / subnormal handling, shifts the
// mantissa and registers the result.
module fp_normalizer_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = FP32_MANT_W,
  parameter int EXP_W  = FP32_EXP_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_normalizer_pipe_if.slave  bus
);

  localparam int SHIFT_W = $clog2(MANT_W + 1);
  // Exponent arithmetic carries one extra bit so that +1 on all-ones cannot wrap.
  localparam int XW = EXP_W + 1;
  localparam int CW = (XW > SHIFT_W) ? XW : SHIFT_W;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic [MANT_W-1:0]  mant;
    logic [EXP_W-1:0]   exp;
    logic [SHIFT_W-1:0] shift;
    logic               sticky;
    norm_flag_e         flag;
  } result_t;

  logic [SHIFT_W-1:0] in_lzc;
  logic               s1_adv;
  logic               in_fire;

  logic               s1_valid;
  logic [MANT_W:0]    s1_mant;
  logic [EXP_W-1:0]   s1_exp;
  logic               s1_sticky;
  logic [SHIFT_W-1:0] s1_lzc;
  logic               s1_carry;
  logic               s1_zero;

  logic               s2_valid;
  result_t            s2_res;

  logic [XW-1:0]      exp_x;
  logic [XW-1:0]      exp_inc;
  logic [CW-1:0]      lzc_c;
  logic [CW-1:0]      expm1_c;
  logic [CW-1:0]      exp_adj_c;
  logic [SHIFT_W-1:0] sub_shift;
  logic [MANT_W-1:0]  frac_norm;
  logic [MANT_W-1:0]  frac_sub;
  result_t            res;

  lzc_count #(.WIDTH(MANT_W)) u_lzc (
    .data  (bus.in_mant[MANT_W-1:0]),
    .count (in_lzc)
  );

  // Handshake. Stage 1 may move forward whenever stage 2 is empty or is being drained.
  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_sticky <= 1'b0;
      s1_lzc    <= '0;
      s1_carry  <= 1'b0;
      s1_zero   <= 1'b0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_mant   <= bus.in_mant;
        s1_exp    <= bus.in_exp;
        s1_sticky <= bus.in_sticky;
        s1_lzc    <= in_lzc;
        s1_carry  <= bus.in_mant[MANT_W];
        s1_zero   <= (bus.in_mant == '0);
      end
    end
  end

  // Stage 2 datapath
  always_comb begin
    exp_x     = {1'b0, s1_exp};
    exp_inc   = exp_x + XW'(1);
    lzc_c     = CW'(s1_lzc);
    expm1_c   = CW'(exp_x) - CW'(1);
    exp_adj_c = CW'(exp_x) - lzc_c;
    // The subnormal path only uses this when the exponent minus one is below
    // lzc. Then it is at most MANT_W, and the truncation to SHIFT_W loses nothing.
    sub_shift = (s1_exp == '0) ? '0 : SHIFT_W'(expm1_c);
    frac_norm = s1_mant[MANT_W-1:0] << s1_lzc;
    frac_sub  = s1_mant[MANT_W-1:0] << sub_shift;

    res        = '0;
    res.sticky = s1_sticky;
    res.flag   = NORM;

    if (s1_carry) begin
      res.sticky = s1_sticky | s1_mant[0];
      if (exp_inc >= EXP_MAX) begin
        res.flag = OVF;
        res.exp  = '1;
        res.mant = '0;
      end else begin
        res.mant = s1_mant[MANT_W:1];
        res.exp  = exp_inc[EXP_W-1:0];
      end
    end else if (s1_zero) begin
      res.flag = ZERO;
    end else if ((s1_exp != '0) && (lzc_c <= expm1_c)) begin
      res.mant  = frac_norm;
      res.exp   = exp_adj_c[EXP_W-1:0];
      res.shift = s1_lzc;
    end else begin
      // Subnormal: shift only as far as the exponent allows, then clamp it to 0.
      // A zero exponent with the MSB already set still ends up normal.
      res.mant  = frac_sub;
      res.exp   = '0;
      res.shift = sub_shift;
      res.flag  = frac_sub[MANT_W-1] ? NORM : DENORM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_res <= res;
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_mant   = s2_res.mant;
  assign bus.out_exp    = s2_res.exp;
  assign bus.out_shift  = s2_res.shift;
  assign bus.out_sticky = s2_res.sticky;
  assign bus.out_zero   = (s2_res.flag == ZERO);
  assign bus.out_denorm = (s2_res.flag == DENORM);
  assign bus.out_ovf    = (s2_res.flag == OVF);

endmodule
